// File: rtl/mem_wb_stage.sv
// MEM stage bus sequencer and MEM/WB pipeline register.
// A load or store holds the front of the pipe until the bus acks or the watchdog expires.
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        startin,
    input  logic [1:0]  MEM_wb,
    input  logic        MEM_branch,
    input  logic        MEM_mem_read,
    input  logic        MEM_mem_write,
    input  logic        MEM_zero,
    input  logic [31:0] MEM_branch_target,
    input  logic [31:0] MEM_alu_result,
    input  logic [31:0] MEM_forward_b_mux_out,
    input  logic [4:0]  MEM_reg_dst_mux_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] pc_branch_target,
    output logic [1:0]  WB_wb,
    output logic [31:0] WB_read_data,
    output logic [31:0] WB_alu_result,
    output logic [4:0]  WB_reg_dst_mux_out,
    output logic        bus_err,
    output logic        align_err,
    output logic [1:0]  dbg_state
);

    // Bus handshake: dmem_req stays high with stable addr/we/wdata until the
    // cycle dmem_ack is seen; dmem_rdata is only sampled in that cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q, wdata_q, cap_q;
    logic        we_q, is_read_q, timed_out_q;

    logic access, misaligned, aligned_access, expire;

    assign access         = MEM_mem_read | MEM_mem_write;
    assign misaligned     = access & (MEM_alu_result[1:0] != 2'b00);
    assign aligned_access = access & ~misaligned;
    assign expire         = (cnt_q == CNT_LAST);

    assign pc_src           = MEM_branch & MEM_zero & (state_q == IDLE);
    assign pc_branch_target = MEM_branch_target;
    assign dbg_state        = state_q;

    always_comb begin
        state_d    = state_q;
        mem_stall  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        case (state_q)
            IDLE: begin
                if (aligned_access) begin
                    mem_stall = ~startin;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                mem_stall  = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                if (dmem_ack || expire) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            state_q            <= IDLE;
            cnt_q              <= 8'd0;
            addr_q             <= 32'd0;
            wdata_q            <= 32'd0;
            cap_q              <= 32'd0;
            we_q               <= 1'b0;
            is_read_q          <= 1'b0;
            timed_out_q        <= 1'b0;
            bus_err            <= 1'b0;
            align_err          <= 1'b0;
            WB_wb              <= 2'b00;
            WB_read_data       <= 32'd0;
            WB_alu_result      <= 32'd0;
            WB_reg_dst_mux_out <= 5'd0;
        end else begin
            state_q <= state_d;
            // Bubble by default; only a plain op or a finished access writes back.
            WB_wb              <= 2'b00;
            WB_read_data       <= 32'd0;
            WB_alu_result      <= 32'd0;
            WB_reg_dst_mux_out <= 5'd0;
            case (state_q)
                IDLE: begin
                    if (aligned_access) begin
                        addr_q      <= MEM_alu_result;
                        wdata_q     <= MEM_forward_b_mux_out;
                        we_q        <= MEM_mem_write;
                        is_read_q   <= MEM_mem_read & ~MEM_mem_write;
                        cnt_q       <= 8'd0;
                        timed_out_q <= 1'b0;
                    end else if (misaligned) begin
                        align_err <= 1'b1;
                    end else begin
                        WB_wb              <= MEM_wb;
                        WB_alu_result      <= MEM_alu_result;
                        WB_reg_dst_mux_out <= MEM_reg_dst_mux_out;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        cap_q <= is_read_q ? dmem_rdata : 32'd0;
                    end else if (expire) begin
                        bus_err     <= 1'b1;
                        timed_out_q <= 1'b1;
                        cap_q       <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    WB_wb              <= timed_out_q ? 2'b00 : MEM_wb;
                    WB_read_data       <= cap_q;
                    WB_alu_result      <= MEM_alu_result;
                    WB_reg_dst_mux_out <= MEM_reg_dst_mux_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: plain ops, loads/stores, timeout, misalignment,
// branch gating and asynchronous reset in the middle of a bus access.
module tb_mem_wb_stage;

  logic        clk;
  logic        startin;
  logic [1:0]  MEM_wb;
  logic        MEM_branch, MEM_mem_read, MEM_mem_write, MEM_zero;
  logic [31:0] MEM_branch_target, MEM_alu_result, MEM_forward_b_mux_out;
  logic [4:0]  MEM_reg_dst_mux_out;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack, mem_stall, pc_src;
  logic [31:0] pc_branch_target;
  logic [1:0]  WB_wb;
  logic [31:0] WB_read_data, WB_alu_result;
  logic [4:0]  WB_reg_dst_mux_out;
  logic        bus_err, align_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int n;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .startin(startin), .MEM_wb(MEM_wb), .MEM_branch(MEM_branch),
    .MEM_mem_read(MEM_mem_read), .MEM_mem_write(MEM_mem_write), .MEM_zero(MEM_zero),
    .MEM_branch_target(MEM_branch_target), .MEM_alu_result(MEM_alu_result),
    .MEM_forward_b_mux_out(MEM_forward_b_mux_out), .MEM_reg_dst_mux_out(MEM_reg_dst_mux_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall), .pc_src(pc_src),
    .pc_branch_target(pc_branch_target), .WB_wb(WB_wb), .WB_read_data(WB_read_data),
    .WB_alu_result(WB_alu_result), .WB_reg_dst_mux_out(WB_reg_dst_mux_out),
    .bus_err(bus_err), .align_err(align_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] wb, input logic [4:0] rd);
    MEM_mem_read          = rd_en;
    MEM_mem_write         = wr_en;
    MEM_alu_result        = addr;
    MEM_forward_b_mux_out = wdata;
    MEM_wb                = wb;
    MEM_reg_dst_mux_out   = rd;
  endtask

  task automatic drive_ack(input logic ack, input logic [31:0] rdata);
    dmem_ack   = ack;
    dmem_rdata = rdata;
  endtask

  initial begin
    startin = 1'b1;
    MEM_branch = 1'b0; MEM_zero = 1'b0; MEM_branch_target = 32'd0;
    drive_op(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 5'd0);
    drive_ack(1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_wb", {30'd0, WB_wb}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_flags", {30'd0, bus_err, align_err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    cycle();
    startin = 1'b0;

    // plain ALU op, first edge after reset
    drive_op(1'b0, 1'b0, 32'h55, 32'h0, 2'b10, 5'd7);
    #1;
    check("nop_stall", {31'd0, mem_stall}, 32'd0);
    cycle();
    check("nop_wb", {30'd0, WB_wb}, 32'd2);
    check("nop_alu", WB_alu_result, 32'h55);
    check("nop_rd", {27'd0, WB_reg_dst_mux_out}, 32'd7);
    check("nop_rdata", WB_read_data, 32'd0);

    // branch taken in IDLE
    MEM_branch = 1'b1; MEM_zero = 1'b1; MEM_branch_target = 32'h400;
    #1;
    check("br_src", {31'd0, pc_src}, 32'd1);
    check("br_tgt", pc_branch_target, 32'h400);

    // load 0x100, ack in second BUSY cycle
    MEM_branch = 1'b0; MEM_zero = 1'b0;
    cycle();
    drive_op(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 5'd3);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    check("ld_stall_idle", {31'd0, mem_stall}, 32'd1);
    check("ld_req_idle", {31'd0, dmem_req}, 32'd0);
    cycle();
    MEM_branch = 1'b1; MEM_zero = 1'b1;
    #1;
    check("ld_req_busy", {31'd0, dmem_req}, 32'd1);
    check("ld_addr", dmem_addr, 32'h100);
    check("ld_we", {31'd0, dmem_we}, 32'd0);
    check("ld_br_gated", {31'd0, pc_src}, 32'd0);
    MEM_branch = 1'b0; MEM_zero = 1'b0;
    cycle();
    drive_ack(1'b1, 32'hDEADBEEF);
    #1;
    check("ld_stall_b2", {31'd0, mem_stall}, 32'd1);
    cycle();
    drive_ack(1'b0, 32'd0);
    #1;
    check("ld_stall_done", {31'd0, mem_stall}, 32'd0);
    check("ld_req_done", {31'd0, dmem_req}, 32'd0);
    check("ld_bubble", {30'd0, WB_wb}, 32'd0);
    cycle();
    drive_op(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
    check("ld_rdata", WB_read_data, exp_q.pop_front());
    check("ld_wb", {30'd0, WB_wb}, 32'd3);
    check("ld_rd", {27'd0, WB_reg_dst_mux_out}, 32'd3);

    // store 0x1234 to 0x20, ack in second BUSY cycle
    drive_op(1'b0, 1'b1, 32'h20, 32'h1234, 2'b00, 5'd0);
    exp_q.push_back(32'h0);
    cycle();
    check("st_req", {31'd0, dmem_req}, 32'd1);
    check("st_we", {31'd0, dmem_we}, 32'd1);
    check("st_addr", dmem_addr, 32'h20);
    check("st_wdata", dmem_wdata, 32'h1234);
    cycle();
    check("st_addr_hold", dmem_addr, 32'h20);
    check("st_wdata_hold", dmem_wdata, 32'h1234);
    drive_ack(1'b1, 32'hFFFF_FFFF);
    cycle();
    drive_ack(1'b0, 32'd0);
    cycle();
    check("st_rdata", WB_read_data, exp_q.pop_front());

    // read and write together: write only, no read data
    drive_op(1'b1, 1'b1, 32'h40, 32'h77, 2'b11, 5'd5);
    exp_q.push_back(32'h0);
    cycle();
    check("rw_we", {31'd0, dmem_we}, 32'd1);
    drive_ack(1'b1, 32'hCAFEF00D);
    cycle();
    drive_ack(1'b0, 32'd0);
    cycle();
    check("rw_rdata", WB_read_data, exp_q.pop_front());

    // ack in the same cycle the watchdog would expire
    drive_op(1'b1, 1'b0, 32'h104, 32'h0, 2'b11, 5'd4);
    exp_q.push_back(32'h0000A5A5);
    repeat (4) cycle();
    check("aw_req", {31'd0, dmem_req}, 32'd1);
    drive_ack(1'b1, 32'h0000A5A5);
    cycle();
    drive_ack(1'b0, 32'd0);
    check("aw_buserr", {31'd0, bus_err}, 32'd0);
    cycle();
    drive_op(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
    check("aw_rdata", WB_read_data, exp_q.pop_front());
    check("aw_wb", {30'd0, WB_wb}, 32'd3);

    // stray ack in IDLE is ignored
    drive_op(1'b0, 1'b0, 32'h8, 32'h0, 2'b10, 5'd1);
    drive_ack(1'b1, 32'h13572468);
    cycle();
    drive_ack(1'b0, 32'd0);
    check("stray_state", {30'd0, dbg_state}, 32'd0);
    check("stray_rdata", WB_read_data, 32'd0);

    // load with no ack: watchdog after 4 BUSY cycles
    drive_op(1'b1, 1'b0, 32'h200, 32'h0, 2'b11, 5'd6);
    exp_q.push_back(32'h0);
    cycle();
    n = 0;
    while (dmem_req === 1'b1 && n < 20) begin
      n++;
      cycle();
    end
    check("to_busy_cycles", n, 32'd4);
    check("to_buserr", {31'd0, bus_err}, 32'd1);
    cycle();
    drive_op(1'b0, 1'b0, 32'h77, 32'h0, 2'b10, 5'd9);
    check("to_wb", {30'd0, WB_wb}, 32'd0);
    check("to_rdata", WB_read_data, exp_q.pop_front());
    cycle();
    check("to_next_wb", {30'd0, WB_wb}, 32'd2);
    check("to_next_alu", WB_alu_result, 32'h77);

    // misaligned load
    drive_op(1'b1, 1'b0, 32'h102, 32'h0, 2'b11, 5'd2);
    #1;
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_stall", {31'd0, mem_stall}, 32'd0);
    cycle();
    check("mis_alignerr", {31'd0, align_err}, 32'd1);
    check("mis_wb", {30'd0, WB_wb}, 32'd0);
    check("mis_state", {30'd0, dbg_state}, 32'd0);
    check("mis_buserr_sticky", {31'd0, bus_err}, 32'd1);

    // asynchronous reset in the middle of BUSY
    drive_op(1'b1, 1'b0, 32'h300, 32'h0, 2'b11, 5'd8);
    cycle();
    check("ar_req_before", {31'd0, dmem_req}, 32'd1);
    #1;
    startin = 1'b1;
    #1;
    check("ar_req", {31'd0, dmem_req}, 32'd0);
    check("ar_stall", {31'd0, mem_stall}, 32'd0);
    check("ar_flags", {30'd0, bus_err, align_err}, 32'd0);
    check("ar_wb", {30'd0, WB_wb}, 32'd0);
    check("ar_state", {30'd0, dbg_state}, 32'd0);
    cycle();
    drive_op(1'b0, 1'b0, 32'h99, 32'h0, 2'b10, 5'd10);
    startin = 1'b0;
    cycle();
    check("ar_first_op_wb", {30'd0, WB_wb}, 32'd2);
    check("ar_first_op_alu", WB_alu_result, 32'h99);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max BUSY cycles without dmem_ack before bus error (range 1..255).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- startin  in  1  reset; asynchronous, active-high.
- MEM_wb  in  2  WB control from EX/MEM; [1]=RegWrite, [0]=MemtoReg.
- MEM_branch  in  1  branch instruction.
- MEM_mem_read  in  1  load.
- MEM_mem_write  in  1  store.
- MEM_zero  in  1  ALU zero flag.
- MEM_branch_target  in  32  branch target.
- MEM_alu_result  in  32  address or ALU result.
- MEM_forward_b_mux_out  in  32  store data.
- MEM_reg_dst_mux_out  in  5  destination register.
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write enable.
- dmem_addr  out  32  bus address.
- dmem_wdata  out  32  bus write data.
- dmem_rdata  in  32  bus read data; valid with dmem_ack.
- dmem_ack  in  1  bus completion.
- mem_stall  out  1  hold IF/ID/EX and EX/MEM.
- pc_src  out  1  take branch.
- pc_branch_target  out  32  branch target to PC mux.
- WB_wb  out  2  registered WB control.
- WB_read_data  out  32  registered load data.
- WB_alu_result  out  32  registered ALU result.
- WB_reg_dst_mux_out  out  5  registered destination register.
- bus_err  out  1  sticky timeout flag.
- align_err  out  1  sticky misaligned-access flag.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-004 Access = MEM_mem_read | MEM_mem_write; misaligned = access & MEM_alu_result[1:0]!=0.
REQ-005 IDLE, no access: mem_stall=0; MEM/WB loads all MEM_* fields; WB_read_data loads 0; stay IDLE.
REQ-006 IDLE, aligned access: mem_stall=1 (combinational); latch addr, wdata, we (=MEM_mem_write); clear timeout counter; go BUSY; MEM/WB loads bubble (WB_wb=0, other WB_* fields 0).
REQ-007 IDLE, misaligned: no bus request; mem_stall=0; set align_err; MEM/WB loads bubble; stay IDLE.
REQ-008 Both MEM_mem_read and MEM_mem_write set: SHALL perform a write only; WB_read_data=0.
REQ-009 BUSY: dmem_req=1; dmem_addr/dmem_we/dmem_wdata driven from latched copies, stable until leaving BUSY; mem_stall=1; MEM/WB loads bubble each cycle.
REQ-010 BUSY, dmem_ack=1: capture dmem_rdata (reads) or 0 (writes); go DONE.
REQ-011 BUSY, no ack: increment counter; when counter reaches TIMEOUT-1, set bus_err, captured data=0, go DONE with writeback suppressed.
REQ-012 Ack and timeout expiry in same cycle: ack wins; no bus_err.
REQ-013 DONE: dmem_req=0; mem_stall=0; MEM/WB loads MEM_wb (forced 00 if timed out), captured data, MEM_alu_result, MEM_reg_dst_mux_out; go IDLE.
REQ-014 Memory-op latency: 3 cycles minimum (IDLE, BUSY with ack, DONE); non-memory ops 1 cycle.
REQ-015 dmem_ack outside BUSY SHALL be ignored.
REQ-016 dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0 whenever not BUSY.
REQ-017 pc_src = MEM_branch & MEM_zero, combinational, forced 0 when FSM not IDLE; pc_branch_target = MEM_branch_target, combinational.
REQ-018 bus_err and align_err SHALL remain set until reset.

Reset
REQ-019 startin=1 SHALL immediately force IDLE, counter 0, all WB_* outputs 0, bus_err=0, align_err=0, dmem_req=0, mem_stall=0, including mid-BUSY.
REQ-020 First clock edge after startin deasserts SHALL be treated as IDLE operation.

Verification
REQ-021 Load addr 0x100, ack in 2nd BUSY cycle, rdata=0xDEADBEEF -> mem_stall high 3 cycles; then WB_read_data=0xDEADBEEF, WB_wb=MEM_wb.
REQ-022 Store addr 0x20, data 0x1234 -> dmem_req=1, dmem_we=1, addr/wdata stable until ack; WB_read_data=0.
REQ-023 Load, no ack, TIMEOUT=4 -> BUSY 4 cycles; bus_err=1; WB_wb=00; next instruction proceeds.
REQ-024 Load addr 0x102 -> no dmem_req; align_err=1; WB_wb=00; mem_stall=0.
REQ-025 MEM_branch=1, MEM_zero=1, target 0x400 in IDLE -> pc_src=1, pc_branch_target=0x400; same inputs during BUSY -> pc_src=0.
REQ-026 startin asserted in BUSY -> dmem_req and mem_stall drop without a clock edge; flags and WB_* outputs cleared.
